// File: rtl/sort_result_serializer_if.sv
// Vector-in / word-out handshake bundle for sort_result_serializer.
// master: sorter and word-sink side (drives vectors and ready). slave: the serializer.
interface sort_result_serializer_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
);
   localparam int unsigned IW = $clog2(DEPTH);

   logic                    vec_valid;
   logic signed [WIDTH-1:0] vec_data [DEPTH];
   logic                    m_valid;
   logic                    m_ready;
   logic signed [WIDTH-1:0] m_data;
   logic [IW-1:0]           m_index;
   logic                    m_last;

   modport master (
      output vec_valid, vec_data, m_ready,
      input  m_valid, m_data, m_index, m_last
   );

   modport slave (
      input  vec_valid, vec_data, m_ready,
      output m_valid, m_data, m_index, m_last
   );
endinterface

// File: rtl/sort_result_serializer.sv
// Buffers sorted vectors in a small vector FIFO and streams them one element per cycle.
// Optional SORT_SER_ORDER_CHECK_EN adds a sticky non-decreasing order check on captured vectors.
module sort_result_serializer #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned FIFO_VECS = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   sort_result_serializer_if.slave          bus,
   input  logic                             clr_flags,
   output logic [$clog2(FIFO_VECS+1)-1:0]   fifo_level,
   output logic                             overflow
`ifdef SORT_SER_ORDER_CHECK_EN
   ,
   output logic                             order_err
`endif
);
   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned LW = $clog2(FIFO_VECS + 1);
   localparam int unsigned PW = (FIFO_VECS > 1) ? $clog2(FIFO_VECS) : 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                  state;
   logic signed [WIDTH-1:0] mem [FIFO_VECS][DEPTH];
   logic [PW-1:0]           rptr;
   logic [PW-1:0]           wptr;
   logic                    hs_c;
   logic                    pop_c;
   logic                    wr_en_c;
   logic                    drop_c;

   // Pointers wrap modulo FIFO_VECS, which need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(FIFO_VECS - 1)) ? '0 : p + PW'(1);
   endfunction

   // A full FIFO still accepts a vector when the head retires on this edge.
   always_comb begin
      hs_c    = bus.m_valid && bus.m_ready;
      pop_c   = hs_c && bus.m_last;
      wr_en_c = bus.vec_valid && ((fifo_level < LW'(FIFO_VECS)) || pop_c);
      drop_c  = bus.vec_valid && !wr_en_c;
   end

   always_ff @(posedge clk) begin
      if (wr_en_c) mem[wptr] <= bus.vec_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         rptr        <= '0;
         wptr        <= '0;
         fifo_level  <= '0;
         overflow    <= 1'b0;
         bus.m_valid <= 1'b0;
         bus.m_data  <= '0;
         bus.m_index <= '0;
         bus.m_last  <= 1'b0;
      end else begin
         if (wr_en_c) wptr <= ptr_inc(wptr);
         if (pop_c)   rptr <= ptr_inc(rptr);
         if (wr_en_c && !pop_c)      fifo_level <= fifo_level + LW'(1);
         else if (pop_c && !wr_en_c) fifo_level <= fifo_level - LW'(1);
         overflow <= (overflow && !clr_flags) || drop_c;

         case (state)
            IDLE: begin
               if (fifo_level != '0) begin
                  state       <= STREAM;
                  bus.m_valid <= 1'b1;
                  bus.m_data  <= mem[rptr][IW'(0)];
                  bus.m_index <= '0;
                  bus.m_last  <= 1'b0;
               end
            end
            STREAM: begin
               if (hs_c) begin
                  if (!bus.m_last) begin
                     bus.m_index <= bus.m_index + IW'(1);
                     bus.m_data  <= mem[rptr][bus.m_index + IW'(1)];
                     bus.m_last  <= (bus.m_index == IW'(DEPTH - 2));
                  end else if (fifo_level > LW'(1)) begin
                     // Next vector already queued: continue without a bubble.
                     bus.m_index <= '0;
                     bus.m_data  <= mem[ptr_inc(rptr)][IW'(0)];
                     bus.m_last  <= 1'b0;
                  end else begin
                     state       <= IDLE;
                     bus.m_valid <= 1'b0;
                     bus.m_data  <= '0;
                     bus.m_index <= '0;
                     bus.m_last  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SORT_SER_ORDER_CHECK_EN
   logic unsorted_c;

   always_comb begin
      unsorted_c = 1'b0;
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
         if (bus.vec_data[i] > bus.vec_data[i+1]) unsorted_c = 1'b1;
      end
   end

   // A new error in the same cycle as a clear keeps the flag set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) order_err <= 1'b0;
      else      order_err <= (order_err && !clr_flags) || (wr_en_c && unsorted_c);
   end
`endif
endmodule

// File: doc/sort_result_serializer.md
# sort_result_serializer

Output-side companion to the bitonic sorter top. It captures each sorted vector that the sorter presents with `valid_out`, buffers it in a small vector FIFO, and streams the elements one word per cycle over a valid/ready handshake, smallest element first. The sorter has no backpressure, so this block absorbs bursts of back-to-back results and reports any vector it is forced to drop.

## Interface
Parameters:
- `WIDTH`, default 32: element width in bits; elements are signed two's complement.
- `DEPTH`, default 8: elements per vector; must be a power of two and at least 2.
- `FIFO_VECS`, default 4: vector FIFO capacity; must be at least 1.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  asynchronous reset, active-low.
- `vec_valid`  in  1  connects to sorter `valid_out`; one vector is offered per cycle it is high.
- `vec_data`  in  signed [WIDTH-1:0] x [DEPTH]  connects to sorter `sorted`; index 0 is the smallest element.
- `m_valid`  out  1  output word valid.
- `m_ready`  in  1  downstream accepts the word.
- `m_data`  out  signed WIDTH  current element.
- `m_index`  out  $clog2(DEPTH)  element position within its vector.
- `m_last`  out  1  high with element `DEPTH-1` of each vector.
- `fifo_level`  out  $clog2(FIFO_VECS+1)  number of vectors stored, including the one being streamed.
- `overflow`  out  1  sticky; at least one vector was dropped.
- `clr_flags`  in  1  synchronous clear of the sticky flags.
- `order_err`  out  1  sticky ordering error; present only with the macro described under Configuration.

## Operation
- **Storage.** Vector FIFO of `FIFO_VECS` entries, `DEPTH*WIDTH` bits each, with wrapping read and write pointers. A word pointer `widx` selects the element of the head vector.
- **Write.** A vector is accepted when `vec_valid` is high and either `fifo_level < FIFO_VECS` or the head vector is being retired in the same cycle.
  - Retirement happens on the handshake of the `m_last` word.
  - When full and not retiring, the vector is dropped and `overflow` is set.
- **Read state machine:**
  - **IDLE:** FIFO empty, `m_valid` = 0.
  - **STREAM:** `m_valid` = 1 and the head word is presented.
  - On handshake (`m_valid && m_ready`):
    - if `widx < DEPTH-1`: `widx` increments;
    - else: `widx` wraps to 0, the head is popped, and the machine stays in STREAM if another vector is queued (no bubble), otherwise goes to IDLE.
- **Output stability.** While `m_valid && !m_ready`, `m_data`, `m_index` and `m_last` hold stable.
- **Data path.** `m_data` passes the stored value unchanged; the block does no arithmetic on elements.
- **Sticky flags.**
  - `clr_flags` clears `overflow` and `order_err`.
  - If a clear and a new error occur in the same cycle, the set wins.

## Timing
- **Reset values:** `m_valid` = 0, `m_data` = 0, `m_index` = 0, `m_last` = 0, `fifo_level` = 0, `overflow` = 0, `order_err` = 0. The FIFO is emptied and the state is IDLE.
- **Latency.** A vector captured at edge T into an empty FIFO has its element 0 on `m_data` with `m_valid` = 1 after edge T+1.
- **Throughput.** One word per cycle while `m_ready` = 1. The last word of vector k is followed by word 0 of vector k+1 on the next cycle. Sustained output rate is 1 vector per `DEPTH` cycles.
- **`fifo_level` update.** Changes on the edge following a write or pop. A write and a pop in the same cycle leave it unchanged.
- **Mid-operation reset.** Asserting `rst` while streaming discards all queued vectors immediately. `m_valid` goes to 0 asynchronously.
- **Pointer wrap.** Read and write pointers wrap modulo `FIFO_VECS`. Full and empty are distinguished by the level count, not pointer equality.

## Configuration
- **`SORT_SER_ORDER_CHECK_EN` defined:**
  - Each accepted vector is checked combinationally for non-decreasing signed order, `vec_data[i] <= vec_data[i+1]` for all i.
  - A failure sets `order_err` at the capture edge.
  - The vector is still stored and streamed unchanged.
- **Undefined:** the `order_err` port is absent and no comparator logic is generated.

## Test plan
Configuration for all scenarios: `WIDTH` = 32, `DEPTH` = 8, `FIFO_VECS` = 4.
- **Single vector.** Send {-10,-3,-1,0,2,4,5,7} with `m_ready` = 1 -> words -10 … 7 on 8 consecutive cycles, `m_index` 0..7, `m_last` only on 7, `fifo_level` 1 then 0, `m_valid` low afterwards.
- **Overflow.** 6 back-to-back vectors (all 0; all 7; all -5; {-10,-3,-1,0,2,4,5,7}; {-2147483648,-123,-1,0,0,1,123,2147483647}; {-2147483648,-100,-50,0,0,50,100,2147483647}) with `m_ready` = 0 -> `fifo_level` = 4, `overflow` = 1 after the 5th vector; vectors 5 and 6 are dropped. Then raise `m_ready` -> exactly 32 words, from vectors 1–4 in order, with no bubbles.
- **Backpressure.** `m_ready` toggles pseudo-randomly -> outputs are held while stalled and no word is lost or duplicated. Compare against a reference queue.
- **Simultaneous full write and retire.** FIFO full and the `m_last` handshake in the same cycle as `vec_valid` -> vector accepted, `overflow` stays 0, `fifo_level` stays 4.
- **Reset and flag clear.**
  - `rst` low while word 3 of vector 2 of 3 is streaming -> all outputs return to reset values; after release, no stale words appear.
  - `clr_flags` asserted in the same cycle as a new drop -> `overflow` remains 1.
- **Order check, `SORT_SER_ORDER_CHECK_EN` defined.** Send {5,-10,0,-3,2,7,-1,4} -> `order_err` = 1 and all 8 words are streamed unchanged. `clr_flags` -> `order_err` = 0.
